fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined RV32I core; the producer side of the IF→ID interface. It owns the PC and issues word fetches to instruction memory over a valid/ready request channel with an in-order response channel. Fetched words pass through a 2-entry buffer into the IF/ID register that drives the decode stage. It also accepts branch/jump redirects from decode and discards wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, word presented to decode when no valid instruction (addi x0,x0,0)
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- stall_i  in  1  hold IF/ID register (decode not accepting)
- ID_branch_en_i  in  1  redirect request from decode
- ID_branch_addr_i  in  32  redirect target
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  32  fetch word address, bits[1:0]=0
- imem_rsp_valid_i  in  1  response valid (always accepted, in request order)
- imem_rsp_data_i  in  32  fetched instruction
- IF_Instruction_o  out  32  IF/ID instruction
- IF_PC_o  out  32  IF/ID PC of that instruction
- IF_valid_o  out  1  IF/ID holds a real instruction

## Operation
- State: fetch_pc (32), pc_fifo (2 entries, PCs of outstanding requests), out_cnt (0..2), ibuf (2 entries of {pc, instr}, buf_cnt 0..2), drop_cnt (0..2), IF/ID register.
- Credit rule: imem_req_valid_o = !rst_i && (out_cnt + buf_cnt < 2). imem_req_addr_o = fetch_pc.
- Accept (req_valid & req_ready): push fetch_pc into pc_fifo, out_cnt+1, fetch_pc += 4 (wraps modulo 2^32).
- Response with drop_cnt>0: discard word, pop pc_fifo, drop_cnt-1, out_cnt-1.
- Response with drop_cnt==0 and out_cnt==0: ignored (stray, e.g. after reset).
- Otherwise: pair with pc_fifo head; pop, out_cnt-1; write to ibuf, or bypass straight into IF/ID if ibuf empty and stall_i=0.
- IF/ID update when stall_i=0: load ibuf head (pop) if buf_cnt>0; else bypassed response if present; else {NOP_INSTR, PC unchanged, valid=0}. Instruction order strictly preserved.
- stall_i=1: IF/ID holds; responses fill ibuf; requests stop when credit exhausted. No loss, no duplication.
- Redirect (ID_branch_en_i=1) has priority over stall_i and all other updates:
  - fetch_pc <= {ID_branch_addr_i[31:2],2'b00}.
  - ibuf cleared; IF/ID <= {NOP_INSTR, valid=0}.
  - drop_cnt <= out_cnt after this edge's accept/response accounting (includes a request accepted same edge; excludes a response consumed same edge, which is itself discarded).
  - A request presented but not accepted in the redirect cycle is withdrawn; address changes to target next cycle.
- New-path responses cannot be mistaken for old: drop_cnt always equals old-path entries at head of pc_fifo.

## Timing
- Reset (async assert): fetch_pc=RESET_PC, out_cnt=buf_cnt=drop_cnt=0, IF_Instruction_o=NOP_INSTR, IF_PC_o=0, IF_valid_o=0, imem_req_valid_o=0 while rst_i high.
- First cycle after rst_i deasserts: imem_req_valid_o=1, addr=RESET_PC.
- Latency: response sampled at edge E → IF/ID valid after E (bypass), when ibuf empty and no stall.
- Single-cycle memory (ready=1, response the cycle after accept): one instruction per cycle sustained; first valid IF/ID one cycle after the first accepted request edge.
- Redirect sampled at edge E: IF_valid_o=0 after E; request to target issued in cycle after E; with 1-cycle memory, target instruction valid in IF/ID two edges after E.
- Max 2 requests outstanding; ibuf never overflows (credit rule).
- Reset mid-operation clears all state immediately; in-flight responses thereafter ignored.

## Test plan
- Reset, 1-cycle memory, sequential code at 0x0 → IF_PC_o 0x0,0x4,0x8… on consecutive cycles, IF_valid_o=1 from second cycle after reset release.
- stall_i high 3 cycles mid-stream at PC 0x10 → IF/ID holds 0x10, max 2 requests issued, release resumes 0x14,0x18 with no gap or duplicate.
- Redirect to 0x103 with 2 responses in flight (2-cycle memory) → both dropped, next valid IF_PC_o=0x100, IF_valid_o=0 in between.
- Redirect asserted together with stall_i and a response arriving → redirect wins, response discarded, IF/ID=NOP, valid=0.
- imem_req_ready_i low 5 cycles → addr stable, no IF/ID advance; fetch_pc=0xFFFF_FFFC wraps next fetch to 0x0.
- rst_i pulsed with 2 requests outstanding → outputs reset immediately; late stray responses ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_stage                                                  |
// | Description : RV32I instruction fetch: PC ownership, credit-limited imem   |
// |               requests, 2-entry instruction buffer, IF/ID register and     |
// |               wrong-path discard on decode redirects.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        ID_branch_en_i,
    input  logic [31:0] ID_branch_addr_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic [31:0] IF_Instruction_o,
    output logic [31:0] IF_PC_o,
    output logic        IF_valid_o
);

    localparam logic [1:0] c_CNT_ZERO = 2'd0;
    localparam logic [1:0] c_CNT_ONE  = 2'd1;

    // Architectural state
    logic [31:0] r_fetch_pc;
    logic [31:0] r_pc_fifo [2];
    logic        r_pcf_wr;
    logic        r_pcf_rd;
    logic [1:0]  r_out_cnt;
    logic [1:0]  r_drop_cnt;
    logic [31:0] r_buf_pc    [2];
    logic [31:0] r_buf_instr [2];
    logic [1:0]  r_buf_cnt;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_if_valid;

    // Combinational next-state
    logic [2:0]  w_credit_sum;
    logic        w_req_valid;
    logic        w_accept;
    logic        w_rsp_drop;
    logic        w_rsp_take;
    logic        w_fifo_pop;
    logic [31:0] w_head_pc;
    logic [31:0] w_branch_target;
    logic [1:0]  w_out_cnt_nxt;
    logic        w_buf_pop;
    logic        w_buf_push;
    logic [1:0]  w_buf_fill;
    logic [1:0]  w_buf_cnt_nxt;
    logic [31:0] w_buf_pc_nxt    [2];
    logic [31:0] w_buf_instr_nxt [2];
    logic [31:0] w_if_instr_nxt;
    logic [31:0] w_if_pc_nxt;
    logic        w_if_valid_nxt;

    // Outstanding plus buffered words never exceed the buffer depth, so a
    // stalled decode can always absorb every response already requested.
    assign w_credit_sum    = {1'b0, r_out_cnt} + {1'b0, r_buf_cnt};
    assign w_req_valid     = !rst_i && (w_credit_sum < 3'd2);
    assign w_accept        = w_req_valid && imem_req_ready_i;
    assign w_rsp_drop      = imem_rsp_valid_i && (r_drop_cnt != c_CNT_ZERO);
    assign w_rsp_take      = imem_rsp_valid_i && (r_drop_cnt == c_CNT_ZERO)
                             && (r_out_cnt != c_CNT_ZERO);
    assign w_fifo_pop      = w_rsp_drop || w_rsp_take;
    assign w_head_pc       = r_pc_fifo[r_pcf_rd];
    assign w_branch_target = ID_branch_addr_i & 32'hFFFF_FFFC;

    assign imem_req_valid_o = w_req_valid;
    assign imem_req_addr_o  = r_fetch_pc;
    assign IF_Instruction_o = r_if_instr;
    assign IF_PC_o          = r_if_pc;
    assign IF_valid_o       = r_if_valid;

    always_comb begin
        w_out_cnt_nxt = r_out_cnt;
        if (w_accept && !w_fifo_pop) begin
            w_out_cnt_nxt = r_out_cnt + c_CNT_ONE;
        end else if (!w_accept && w_fifo_pop) begin
            w_out_cnt_nxt = r_out_cnt - c_CNT_ONE;
        end
    end

    // Instruction buffer and IF/ID register; a taken response on a redirect
    // edge is simply not written anywhere, which discards it.
    always_comb begin
        w_buf_pc_nxt[0]    = r_buf_pc[0];
        w_buf_pc_nxt[1]    = r_buf_pc[1];
        w_buf_instr_nxt[0] = r_buf_instr[0];
        w_buf_instr_nxt[1] = r_buf_instr[1];
        w_buf_cnt_nxt      = r_buf_cnt;
        w_buf_pop          = 1'b0;
        w_buf_push         = 1'b0;
        w_buf_fill         = r_buf_cnt;
        w_if_instr_nxt     = r_if_instr;
        w_if_pc_nxt        = r_if_pc;
        w_if_valid_nxt     = r_if_valid;

        if (ID_branch_en_i) begin
            w_buf_cnt_nxt  = c_CNT_ZERO;
            w_if_instr_nxt = NOP_INSTR;
            w_if_valid_nxt = 1'b0;
        end else begin
            w_buf_pop  = !stall_i && (r_buf_cnt != c_CNT_ZERO);
            w_buf_push = w_rsp_take && (stall_i || (r_buf_cnt != c_CNT_ZERO));

            if (!stall_i) begin
                if (r_buf_cnt != c_CNT_ZERO) begin
                    w_if_instr_nxt = r_buf_instr[0];
                    w_if_pc_nxt    = r_buf_pc[0];
                    w_if_valid_nxt = 1'b1;
                end else if (w_rsp_take) begin
                    w_if_instr_nxt = imem_rsp_data_i;
                    w_if_pc_nxt    = w_head_pc;
                    w_if_valid_nxt = 1'b1;
                end else begin
                    w_if_instr_nxt = NOP_INSTR;
                    w_if_valid_nxt = 1'b0;
                end
            end

            if (w_buf_pop) begin
                w_buf_pc_nxt[0]    = r_buf_pc[1];
                w_buf_instr_nxt[0] = r_buf_instr[1];
                w_buf_fill         = r_buf_cnt - c_CNT_ONE;
            end

            if (w_buf_push) begin
                if (w_buf_fill == c_CNT_ZERO) begin
                    w_buf_pc_nxt[0]    = w_head_pc;
                    w_buf_instr_nxt[0] = imem_rsp_data_i;
                end else begin
                    w_buf_pc_nxt[1]    = w_head_pc;
                    w_buf_instr_nxt[1] = imem_rsp_data_i;
                end
            end

            w_buf_cnt_nxt = w_buf_fill + {1'b0, w_buf_push};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_pc     <= RESET_PC;
            r_pc_fifo[0]   <= 32'h0;
            r_pc_fifo[1]   <= 32'h0;
            r_pcf_wr       <= 1'b0;
            r_pcf_rd       <= 1'b0;
            r_out_cnt      <= c_CNT_ZERO;
            r_drop_cnt     <= c_CNT_ZERO;
            r_buf_pc[0]    <= 32'h0;
            r_buf_pc[1]    <= 32'h0;
            r_buf_instr[0] <= 32'h0;
            r_buf_instr[1] <= 32'h0;
            r_buf_cnt      <= c_CNT_ZERO;
            r_if_instr     <= NOP_INSTR;
            r_if_pc        <= 32'h0;
            r_if_valid     <= 1'b0;
        end else begin
            if (ID_branch_en_i) begin
                r_fetch_pc <= w_branch_target;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (w_accept) begin
                r_pc_fifo[r_pcf_wr] <= r_fetch_pc;
                r_pcf_wr            <= ~r_pcf_wr;
            end
            if (w_fifo_pop) begin
                r_pcf_rd <= ~r_pcf_rd;
            end
            r_out_cnt <= w_out_cnt_nxt;

            // Everything still outstanding after a redirect edge is old-path
            // and sits at the head of the PC FIFO.
            if (ID_branch_en_i) begin
                r_drop_cnt <= w_out_cnt_nxt;
            end else if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - c_CNT_ONE;
            end

            r_buf_pc[0]    <= w_buf_pc_nxt[0];
            r_buf_pc[1]    <= w_buf_pc_nxt[1];
            r_buf_instr[0] <= w_buf_instr_nxt[0];
            r_buf_instr[1] <= w_buf_instr_nxt[1];
            r_buf_cnt      <= w_buf_cnt_nxt;
            r_if_instr     <= w_if_instr_nxt;
            r_if_pc        <= w_if_pc_nxt;
            r_if_valid     <= w_if_valid_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_stage                                               |
// | Description : Directed bench for fetch_stage with a fixed-latency imem.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        ID_branch_en_i;
    logic [31:0] ID_branch_addr_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic [31:0] IF_Instruction_o;
    logic [31:0] IF_PC_o;
    logic        IF_valid_o;

    int          n_vec;
    int          n_bad;
    int          cyc_n;
    int          lat;
    logic        sched_v [8];
    logic [31:0] sched_a [8];
    logic        req_v_seen;
    logic [31:0] req_a_seen;

    fetch_stage dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .stall_i          (stall_i),
        .ID_branch_en_i   (ID_branch_en_i),
        .ID_branch_addr_i (ID_branch_addr_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .IF_Instruction_o (IF_Instruction_o),
        .IF_PC_o          (IF_PC_o),
        .IF_valid_o       (IF_valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr);
        chk({tag, ".valid"}, {31'h0, IF_valid_o}, {31'h0, v});
        chk({tag, ".pc"}, IF_PC_o, pc);
        chk({tag, ".instr"}, IF_Instruction_o, instr);
    endtask

    task automatic chk_nop(input string tag);
        chk({tag, ".valid"}, {31'h0, IF_valid_o}, 32'h0);
        chk({tag, ".instr"}, IF_Instruction_o, c_NOP);
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
        chk({tag, ".rv"}, {31'h0, req_v_seen}, {31'h0, v});
        if (v) chk({tag, ".ra"}, req_a_seen, a);
    endtask

    // One clock cycle: inputs change at negedge, memory sees the request just
    // before the rising edge, outputs are examined 1 time unit after it.
    task automatic cyc(input logic rst, input logic stall, input logic ready,
                       input logic br, input logic [31:0] br_addr);
        @(negedge clk_i);
        rst_i            = rst;
        stall_i          = stall;
        imem_req_ready_i = ready;
        ID_branch_en_i   = br;
        ID_branch_addr_i = br_addr;
        imem_rsp_valid_i = sched_v[cyc_n % 8];
        imem_rsp_data_i  = sched_v[cyc_n % 8] ? word_of(sched_a[cyc_n % 8]) : 32'hDEAD_BEEF;
        sched_v[cyc_n % 8] = 1'b0;
        #1;
        req_v_seen = imem_req_valid_o;
        req_a_seen = imem_req_addr_o;
        if (imem_req_valid_o && imem_req_ready_i) begin
            sched_v[(cyc_n + lat) % 8] = 1'b1;
            sched_a[(cyc_n + lat) % 8] = imem_req_addr_o;
        end
        @(posedge clk_i);
        #1;
        cyc_n++;
    endtask

    task automatic run(input logic stall, input logic ready);
        cyc(1'b0, stall, ready, 1'b0, 32'h0);
    endtask

    task automatic reset3();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cyc_n = 0; lat = 1;
        for (int i = 0; i < 8; i++) begin
            sched_v[i] = 1'b0;
            sched_a[i] = 32'h0;
        end
        rst_i = 1'b1; stall_i = 1'b0; ID_branch_en_i = 1'b0; ID_branch_addr_i = 32'h0;
        imem_req_ready_i = 1'b1; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0;
        req_v_seen = 1'b0; req_a_seen = 32'h0;

        // Reset and sequential stream with 1-cycle memory
        reset3();
        chk("rst.req_valid", {31'h0, imem_req_valid_o}, 32'h0);
        chk_ifid("rst", 1'b0, 32'h0, c_NOP);
        run(0, 1);  chk_req("seq.c0", 1'b1, 32'h0);  chk_nop("seq.c0");
        run(0, 1);  chk_ifid("seq.c1", 1'b1, 32'h0, word_of(32'h0));
        run(0, 1);  chk_ifid("seq.c2", 1'b1, 32'h4, word_of(32'h4));
        run(0, 1);  chk("seq.c3.pc", IF_PC_o, 32'h8);
        run(0, 1);  chk("seq.c4.pc", IF_PC_o, 32'hC);
        run(0, 1);  chk_ifid("seq.c5", 1'b1, 32'h10, word_of(32'h10));

        // Three stall cycles holding PC 0x10
        run(1, 1);  chk_req("stl.c6", 1'b1, 32'h18);  chk("stl.c6.pc", IF_PC_o, 32'h10);
        run(1, 1);  chk_req("stl.c7", 1'b0, 32'h0);
        run(1, 1);  chk_req("stl.c8", 1'b0, 32'h0);   chk_ifid("stl.c8", 1'b1, 32'h10, word_of(32'h10));
        run(0, 1);  chk_req("stl.c9", 1'b0, 32'h0);   chk_ifid("stl.c9", 1'b1, 32'h14, word_of(32'h14));
        run(0, 1);  chk_req("stl.c10", 1'b1, 32'h1C); chk_ifid("stl.c10", 1'b1, 32'h18, word_of(32'h18));
        run(0, 1);  chk_ifid("stl.c11", 1'b1, 32'h1C, word_of(32'h1C));
        run(0, 1);  chk_ifid("stl.c12", 1'b1, 32'h20, word_of(32'h20));

        // Redirect to 0x103 with two old-path words in flight, 2-cycle memory
        lat = 2;
        reset3();
        run(0, 1); run(0, 1); run(0, 1);
        run(0, 1);  chk_ifid("br.c3", 1'b1, 32'h4, word_of(32'h4));
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        chk_nop("br.c4");
        run(0, 1);  chk_req("br.c5", 1'b0, 32'h0);    chk_nop("br.c5");
        run(0, 1);  chk_req("br.c6", 1'b1, 32'h100);  chk_nop("br.c6");
        run(0, 1);  chk_nop("br.c7");
        run(0, 1);  chk_ifid("br.c8", 1'b1, 32'h100, word_of(32'h100));

        // Redirect together with stall and a live response
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk_nop("brs.c9");
        run(0, 1);  chk_req("brs.c10", 1'b1, 32'h200); chk_nop("brs.c10");
        run(0, 1);  chk_nop("brs.c11");
        run(0, 1);  chk_ifid("brs.c12", 1'b1, 32'h200, word_of(32'h200));

        // Ready low for five cycles, then wrap past 0xFFFF_FFFC
        lat = 1;
        reset3();
        run(0, 1);
        run(0, 0);  chk_ifid("rdy.c1", 1'b1, 32'h0, word_of(32'h0));
        run(0, 0);  chk_req("rdy.c2", 1'b1, 32'h4);    chk_nop("rdy.c2");
        run(0, 0);
        run(0, 0);
        run(0, 0);  chk_req("rdy.c5", 1'b1, 32'h4);    chk_nop("rdy.c5");
        run(0, 1);  chk_req("rdy.c6", 1'b1, 32'h4);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        chk_req("wrap.c7", 1'b1, 32'h8);  chk_nop("wrap.c7");
        run(0, 1);  chk_req("wrap.c8", 1'b1, 32'hFFFF_FFFC); chk_nop("wrap.c8");
        run(0, 1);  chk_req("wrap.c9", 1'b1, 32'h0);
        chk_ifid("wrap.c9", 1'b1, 32'hFFFF_FFFC, word_of(32'hFFFF_FFFC));
        run(0, 1);  chk_ifid("wrap.c10", 1'b1, 32'h0, word_of(32'h0));

        // Asynchronous reset with two requests outstanding
        lat = 2;
        reset3();
        run(0, 1); run(0, 1); run(0, 1);
        run(0, 1);  chk_ifid("ar.c3", 1'b1, 32'h4, word_of(32'h4));
        run(1, 1);  chk_ifid("ar.c4", 1'b1, 32'h4, word_of(32'h4));
        rst_i = 1'b1;
        #1;
        chk("ar.async.rv", {31'h0, imem_req_valid_o}, 32'h0);
        chk_ifid("ar.async", 1'b0, 32'h0, c_NOP);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        run(0, 0);  chk_req("ar.c6", 1'b1, 32'h0);    chk_ifid("ar.c6", 1'b0, 32'h0, c_NOP);
        run(0, 1);  chk_req("ar.c7", 1'b1, 32'h0);    chk_nop("ar.c7");
        run(0, 1);  chk_req("ar.c8", 1'b1, 32'h4);    chk_nop("ar.c8");
        run(0, 1);  chk_ifid("ar.c9", 1'b1, 32'h0, word_of(32'h0));
        run(0, 1);  chk_ifid("ar.c10", 1'b1, 32'h4, word_of(32'h4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
